// File: rtl/gerenciador_partida.sv
// Battleship match controller: latches a ship map, runs a shot-limited attack and drives the LED bitmap.
// Shots and erro update at the confirm edge; matriz and win/loss follow one edge later.
module gerenciador_partida #(
  parameter int LINHAS    = 7,
  parameter int COLUNAS   = 5,
  parameter int MAX_TIROS = 15,
  parameter int BLINK_DIV = 50000,
  localparam int N  = LINHAS * COLUNAS,
  localparam int LW = $clog2(LINHAS),
  localparam int CW = $clog2(COLUNAS),
  localparam int TW = $clog2(MAX_TIROS + 1),
  localparam int AW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [1:0]    modo,
  input  logic          confirmar,
  input  logic [N-1:0]  mapa_in,
  input  logic [LW-1:0] linha,
  input  logic [CW-1:0] coluna,
  output logic [N-1:0]  matriz,
  output logic [TW-1:0] tiros_restantes,
  output logic [AW-1:0] acertos,
  output logic [2:0]    estado,
  output logic          erro,
  output logic          fim
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [TW-1:0] MAX_T      = TW'(MAX_TIROS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    PREPARACAO = 3'd1,
    ATAQUE     = 3'd2,
    VITORIA    = 3'd3,
    DERROTA    = 3'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic          conf_q;
  logic [N-1:0]  mapa_q, mapa_d;
  logic          mapa_valido_q, mapa_valido_d;
  logic [N-1:0]  tiros_q, tiros_d;
  logic [TW-1:0] restantes_q, restantes_d;
  logic [AW-1:0] acertos_q, acertos_d;
  logic          erro_q, erro_d;
  logic [N-1:0]  matriz_q, matriz_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          fase_q, fase_d;

  logic          pulso;
  logic          modo_off;
  logic          ganhou;
  logic          sem_tiros;
  logic          entra_ataque;
  logic          tiro_en;
  logic          carga_en;
  logic          tiro_fora;
  logic          tiro_repetido;
  logic          tiro_acerto;
  int            idx;
  logic [N-1:0]  sel;
  logic [N-1:0]  fase_n;

  assign pulso     = confirmar & ~conf_q;
  assign modo_off  = (modo == 2'b00) || (modo == 2'b11);
  assign ganhou    = ~|(mapa_q & ~tiros_q);
  assign sem_tiros = (restantes_q == '0);

  // Out-of-range coordinates never reach the shift, so idx may be garbage then.
  assign tiro_fora     = (int'(linha) >= LINHAS) || (int'(coluna) >= COLUNAS);
  assign idx           = int'(linha) * COLUNAS + int'(coluna);
  assign sel           = N'(1) << idx;
  assign tiro_repetido = |(tiros_q & sel);
  assign tiro_acerto   = |(mapa_q & sel);

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= DESLIGADO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // FSM: next state
  always_comb begin
    estado_d = estado_q;
    if (modo_off) begin
      estado_d = DESLIGADO;
    end else if (modo == 2'b01) begin
      estado_d = PREPARACAO;
    end else begin
      case (estado_q)
        DESLIGADO, PREPARACAO: begin
          if (mapa_valido_q) estado_d = ATAQUE;
        end
        ATAQUE: begin
          if (ganhou)         estado_d = VITORIA;
          else if (sem_tiros) estado_d = DERROTA;
        end
        VITORIA, DERROTA: estado_d = estado_q;
        default:          estado_d = DESLIGADO;
      endcase
    end
  end

  // FSM: outputs; a pulse only acts when the mode is not leaving the current state
  always_comb begin
    fim          = (estado_q == VITORIA) || (estado_q == DERROTA);
    entra_ataque = (estado_d == ATAQUE) && (estado_q != ATAQUE);
    tiro_en      = pulso && (estado_q == ATAQUE) && (estado_d == ATAQUE);
    carga_en     = pulso && (estado_q == PREPARACAO) && (modo == 2'b01);
  end

  always_comb begin
    mapa_d        = mapa_q;
    mapa_valido_d = mapa_valido_q;
    tiros_d       = tiros_q;
    restantes_d   = restantes_q;
    acertos_d     = acertos_q;
    erro_d        = 1'b0;
    if (carga_en) begin
      mapa_d        = mapa_in;
      mapa_valido_d = 1'b1;
    end
    if (entra_ataque) begin
      tiros_d     = '0;
      acertos_d   = '0;
      restantes_d = MAX_T;
    end else if (tiro_en) begin
      if (tiro_fora || tiro_repetido) begin
        erro_d = 1'b1;
      end else begin
        tiros_d     = tiros_q | sel;
        restantes_d = restantes_q - TW'(1);
        if (tiro_acerto) acertos_d = acertos_q + AW'(1);
      end
    end
  end

  always_comb begin
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      fase_d      = ~fase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      fase_d      = fase_q;
    end
  end

  always_comb begin
    fase_n = {N{fase_q}};
    case (estado_q)
      PREPARACAO: matriz_d = mapa_in;
      ATAQUE:     matriz_d = (tiros_q & mapa_q) | (tiros_q & ~mapa_q & fase_n);
      VITORIA:    matriz_d = mapa_q;
      DERROTA:    matriz_d = (tiros_q & mapa_q) | (~tiros_q & mapa_q & fase_n);
      default:    matriz_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conf_q        <= 1'b0;
      mapa_q        <= '0;
      mapa_valido_q <= 1'b0;
      tiros_q       <= '0;
      restantes_q   <= '0;
      acertos_q     <= '0;
      erro_q        <= 1'b0;
      matriz_q      <= '0;
      blink_cnt_q   <= '0;
      fase_q        <= 1'b0;
    end else begin
      conf_q        <= confirmar;
      mapa_q        <= mapa_d;
      mapa_valido_q <= mapa_valido_d;
      tiros_q       <= tiros_d;
      restantes_q   <= restantes_d;
      acertos_q     <= acertos_d;
      erro_q        <= erro_d;
      matriz_q      <= matriz_d;
      blink_cnt_q   <= blink_cnt_d;
      fase_q        <= fase_d;
    end
  end

  assign matriz          = matriz_q;
  assign tiros_restantes = restantes_q;
  assign acertos         = acertos_q;
  assign estado          = estado_q;
  assign erro            = erro_q;

endmodule

// File: tb/tb_gerenciador_partida.sv
// Bench for gerenciador_partida: main 7x5 instance tracked every cycle by a reference model,
// plus a 3-shot instance for loss/blink and an 8x8 instance for the top cell.
module tb_gerenciador_partida;

  localparam int L   = 7;
  localparam int C   = 5;
  localparam int NC  = L * C;
  localparam int MT  = 15;
  localparam int BD  = 6;
  localparam int LBD = 5;

  logic        clock;
  logic        reset_n;
  logic [1:0]  modo;
  logic        confirmar;
  logic [34:0] mapa35;
  logic [63:0] mapa64;
  logic [2:0]  linha;
  logic [2:0]  coluna;

  logic [34:0] a_matriz;
  logic [3:0]  a_rest;
  logic [5:0]  a_hits;
  logic [2:0]  a_estado;
  logic        a_erro, a_fim;

  logic [34:0] l_matriz;
  logic [1:0]  l_rest;
  logic [5:0]  l_hits;
  logic [2:0]  l_estado;
  logic        l_erro, l_fim;

  logic [63:0] b_matriz;
  logic [3:0]  b_rest;
  logic [6:0]  b_hits;
  logic [2:0]  b_estado;
  logic        b_erro, b_fim;

  gerenciador_partida #(.LINHAS(7), .COLUNAS(5), .MAX_TIROS(15), .BLINK_DIV(BD)) u_dut (
    .clock(clock), .reset_n(reset_n), .modo(modo), .confirmar(confirmar), .mapa_in(mapa35),
    .linha(linha), .coluna(coluna), .matriz(a_matriz), .tiros_restantes(a_rest),
    .acertos(a_hits), .estado(a_estado), .erro(a_erro), .fim(a_fim));

  gerenciador_partida #(.LINHAS(7), .COLUNAS(5), .MAX_TIROS(3), .BLINK_DIV(LBD)) u_loss (
    .clock(clock), .reset_n(reset_n), .modo(modo), .confirmar(confirmar), .mapa_in(mapa35),
    .linha(linha), .coluna(coluna), .matriz(l_matriz), .tiros_restantes(l_rest),
    .acertos(l_hits), .estado(l_estado), .erro(l_erro), .fim(l_fim));

  gerenciador_partida #(.LINHAS(8), .COLUNAS(8), .MAX_TIROS(15), .BLINK_DIV(4)) u_big (
    .clock(clock), .reset_n(reset_n), .modo(modo), .confirmar(confirmar), .mapa_in(mapa64),
    .linha(linha), .coluna(coluna), .matriz(b_matriz), .tiros_restantes(b_rest),
    .acertos(b_hits), .estado(b_estado), .erro(b_erro), .fim(b_fim));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the 7x5 instance: sets of fired cells and the map in play.
  int          r_st;
  logic [34:0] r_mapa, r_jogo, r_fired, r_mat;
  bit          r_valido, r_played, r_conf, r_erro;
  int          r_edges;

  function automatic int popc(logic [34:0] v);
    int n = 0;
    for (int i = 0; i < NC; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int exp_rest();
    return r_played ? MT - popc(r_fired) : 0;
  endfunction

  function automatic int exp_hits();
    return r_played ? popc(r_fired & r_jogo) : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    r_st = 0; r_mapa = '0; r_jogo = '0; r_fired = '0; r_mat = '0;
    r_valido = 0; r_played = 0; r_conf = 0; r_erro = 0; r_edges = 0;
  endtask

  task automatic model_edge();
    bit          pulse, fase;
    int          nxt, idx;
    logic [34:0] mat;
    pulse = confirmar && !r_conf;
    fase  = ((r_edges / BD) % 2) == 1;
    for (int i = 0; i < NC; i++) begin
      case (r_st)
        1:       mat[i] = mapa35[i];
        2:       mat[i] = r_fired[i] ? (r_mapa[i] ? 1'b1 : fase) : 1'b0;
        3:       mat[i] = r_mapa[i];
        4:       mat[i] = r_mapa[i] ? (r_fired[i] ? 1'b1 : fase) : 1'b0;
        default: mat[i] = 1'b0;
      endcase
    end
    if (modo == 2'd0 || modo == 2'd3) nxt = 0;
    else if (modo == 2'd1)            nxt = 1;
    else if (r_st <= 1)               nxt = r_valido ? 2 : r_st;
    else if (r_st == 2)               nxt = (popc(r_mapa & ~r_fired) == 0) ? 3 : (exp_rest() == 0 ? 4 : 2);
    else                              nxt = r_st;
    r_erro = 0;
    if (pulse && r_st == 1 && modo == 2'd1) begin
      r_mapa = mapa35; r_valido = 1;
    end
    if (r_st != 2 && nxt == 2) begin
      r_fired = '0; r_played = 1; r_jogo = r_mapa;
    end else if (pulse && r_st == 2 && nxt == 2) begin
      if (int'(linha) >= L || int'(coluna) >= C) r_erro = 1;
      else begin
        idx = int'(linha) * C + int'(coluna);
        if (r_fired[idx]) r_erro = 1;
        else r_fired[idx] = 1'b1;
      end
    end
    r_mat = mat; r_st = nxt; r_conf = confirmar; r_edges++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("estado", 64'(a_estado), 64'(r_st));
    chk("tiros_restantes", 64'(a_rest), 64'(exp_rest()));
    chk("acertos", 64'(a_hits), 64'(exp_hits()));
    chk("erro", 64'(a_erro), 64'(r_erro));
    chk("fim", 64'(a_fim), 64'(r_st >= 3));
    chk("matriz", 64'(a_matriz), 64'(r_mat));
  endtask

  // Called just after a rising edge; reset is asserted and released between edges.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_estado", 64'(a_estado), 64'(0));
    chk("rst_matriz", 64'(a_matriz), 64'(0));
    chk("rst_rest", 64'(a_rest), 64'(0));
    chk("rst_acertos", 64'(a_hits), 64'(0));
    chk("rst_erro", 64'(a_erro), 64'(0));
    chk("rst_fim", 64'(a_fim), 64'(0));
    chk("rst_loss_estado", 64'(l_estado), 64'(0));
    chk("rst_big_estado", 64'(b_estado), 64'(0));
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic load_and_attack(input logic [34:0] m35, input logic [63:0] m64);
    modo = 2'b01; mapa35 = m35; mapa64 = m64; tick();
    confirmar = 1'b1; tick();
    confirmar = 1'b0; modo = 2'b10; tick();
  endtask

  task automatic shot(input int lin, input int col);
    linha = 3'(lin); coluna = 3'(col); confirmar = 1'b1; tick();
    confirmar = 1'b0; tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          prev;
    int          k, r, start, pick;
    logic [34:0] m;
    reset_n = 1'b1; modo = 2'b00; confirmar = 1'b0;
    mapa35 = '0; mapa64 = '0; linha = '0; coluna = '0;
    model_reset();
    @(posedge clock); #1;
    do_reset();
    tick();
    chk("post_reset_estado", 64'(a_estado), 64'(0));

    // Single-ship map, one hit wins
    load_and_attack(35'h1, 64'h0);
    chk("enter_rest", 64'(a_rest), 64'(15));
    linha = 3'd0; coluna = 3'd0; confirmar = 1'b1; tick();
    chk("hit_acertos", 64'(a_hits), 64'(1));
    chk("hit_rest", 64'(a_rest), 64'(14));
    confirmar = 1'b0; tick();
    chk("win_estado", 64'(a_estado), 64'(3));
    tick();
    chk("win_matriz", 64'(a_matriz), 64'(35'h1));

    // Rejections: out of range row, repeated cell, out of range column
    load_and_attack(35'h4_0002_0000, 64'h0);
    linha = 3'd7; coluna = 3'd0; confirmar = 1'b1; tick();
    chk("oor_erro", 64'(a_erro), 64'(1));
    chk("oor_rest", 64'(a_rest), 64'(15));
    confirmar = 1'b0; tick();
    chk("oor_erro_pulse", 64'(a_erro), 64'(0));
    shot(1, 1);
    chk("miss_rest", 64'(a_rest), 64'(14));
    linha = 3'd1; coluna = 3'd1; confirmar = 1'b1; tick();
    chk("dup_erro", 64'(a_erro), 64'(1));
    chk("dup_rest", 64'(a_rest), 64'(14));
    confirmar = 1'b0; tick();
    linha = 3'd2; coluna = 3'd5; confirmar = 1'b1; tick();
    chk("col_oor_erro", 64'(a_erro), 64'(1));
    confirmar = 1'b0; tick();

    // Reset mid-match drops everything, including the map
    do_reset();
    tick();
    chk("reset_mid_estado", 64'(a_estado), 64'(0));
    modo = 2'b10; tick(); tick(); tick();
    chk("nomap_estado", 64'(a_estado), 64'(0));

    // Mode change on the same cycle as a pulse discards the shot
    load_and_attack(35'h10_0000, 64'h0);
    tick();
    modo = 2'b01; linha = 3'd4; coluna = 3'd0; confirmar = 1'b1; tick();
    chk("conc_estado", 64'(a_estado), 64'(1));
    chk("conc_rest", 64'(a_rest), 64'(15));
    chk("conc_acertos", 64'(a_hits), 64'(0));
    modo = 2'b10; tick();
    confirmar = 1'b0; tick();

    // Randomized matches against the model
    for (int mt = 0; mt < 25; mt++) begin
      if ($urandom_range(0, 2) == 0) begin
        modo = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11; tick();
      end
      m = '0;
      if ($urandom_range(0, 7) != 0)
        for (int i = 0; i < NC; i++) m[i] = ($urandom_range(0, 5) == 0);
      load_and_attack(m, 64'h0);
      tick();
      for (int s = 0; s < 40 && r_st == 2; s++) begin
        r = $urandom_range(0, 11);
        if (r == 0) begin
          linha = 3'd7; coluna = 3'($urandom_range(0, 7));
        end else if (r == 1) begin
          linha = 3'($urandom_range(0, 6)); coluna = 3'($urandom_range(5, 7));
        end else if (r == 2) begin
          // repeat the previous coordinates
        end else begin
          pick = -1;
          start = $urandom_range(0, NC - 1);
          if (r < 7)
            for (int i = 0; i < NC; i++)
              if (pick < 0 && r_mapa[(start + i) % NC] && !r_fired[(start + i) % NC]) pick = (start + i) % NC;
          if (pick < 0) pick = start;
          linha = 3'(pick / C); coluna = 3'(pick % C);
        end
        if ($urandom_range(0, 15) == 0) begin
          modo = 2'b01; confirmar = 1'b1; tick();
          confirmar = 1'b0; tick();
          break;
        end
        confirmar = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        confirmar = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      repeat ($urandom_range(2, 4)) tick();
    end

    // Loss on the 3-shot instance, top cell on the 8x8 instance
    @(posedge clock); #1;
    do_reset();
    load_and_attack(35'h4_0000_0000, 64'h8000_0000_0000_0000);
    chk("loss_enter_rest", 64'(l_rest), 64'(3));
    chk("big_enter_rest", 64'(b_rest), 64'(15));
    shot(0, 0);
    shot(0, 1);
    linha = 3'd0; coluna = 3'd2; confirmar = 1'b1; tick();
    chk("loss_rest_zero", 64'(l_rest), 64'(0));
    confirmar = 1'b0; tick();
    chk("loss_estado", 64'(l_estado), 64'(4));
    chk("loss_fim", 64'(l_fim), 64'(1));
    chk("big_rest", 64'(b_rest), 64'(12));
    tick();
    chk("loss_misses_dark", 64'(l_matriz[2:0]), 64'(0));
    prev = l_matriz[34]; k = 0;
    while (l_matriz[34] === prev && k < 3 * LBD) begin tick(); k++; end
    chk("loss_blink_seen", 64'(l_matriz[34] !== prev), 64'(1));
    for (int rep = 0; rep < 2; rep++) begin
      prev = l_matriz[34]; k = 0;
      while (l_matriz[34] === prev && k < 3 * LBD) begin tick(); k++; end
      chk("loss_blink_period", 64'(k), 64'(LBD));
    end

    linha = 3'd7; coluna = 3'd7; confirmar = 1'b1; tick();
    chk("big_hit63", 64'(b_hits), 64'(1));
    chk("big_erro", 64'(b_erro), 64'(0));
    chk("loss_ignores_pulse", 64'(l_erro), 64'(0));
    confirmar = 1'b0; tick();
    chk("big_win", 64'(b_estado), 64'(3));
    chk("loss_holds", 64'(l_estado), 64'(4));
    tick();
    chk("big_matriz", b_matriz, 64'h8000_0000_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
